// File: rtl/noc_traffic_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared types and constants for the NoC traffic monitor.
//               It holds the monitor state encoding, the default widths and
//               the seed and taps of the backpressure LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned C_DEF_NUM_PE     = 8;
  localparam int unsigned C_DEF_DATA_WIDTH = 32;
  localparam int unsigned C_DEF_PKT_LIMIT  = 100;
  localparam int unsigned C_DEF_TS_WIDTH   = 16;

  // 32-bit Galois LFSR, x^32 + x^22 + x^2 + x + 1. Bit k drives ready of
  // channel k, so this register supports up to 32 channels.
  localparam int unsigned C_LFSR_WIDTH = 32;
  localparam logic [31:0] C_LFSR_SEED  = 32'h0000_0001;
  localparam logic [31:0] C_LFSR_TAPS  = 32'h8020_0003;

endpackage
`default_nettype wire

// File: rtl/noc_traffic_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_traffic_monitor_if
// Description : Bundle of the per-channel packet bus between the NoC egress
//               ports (master) and the traffic monitor (slave).
//   i_data       : NUM_PE packets, channel k at [k*TOTAL_WIDTH +: TOTAL_WIDTH]
//   i_data_valid : per-channel valid
//   o_data_ready : per-channel ready, driven by the monitor
// Revision    : 1.0 - initial release
// ============================================================================
interface noc_traffic_monitor_if #(
  parameter int unsigned NUM_PE      = 8,
  parameter int unsigned TOTAL_WIDTH = 35
);
  logic [NUM_PE*TOTAL_WIDTH-1:0] i_data;
  logic [NUM_PE-1:0]             i_data_valid;
  logic [NUM_PE-1:0]             o_data_ready;

  modport master (output i_data, output i_data_valid, input o_data_ready);
  modport slave  (input i_data, input i_data_valid, output o_data_ready);
endinterface
`default_nettype wire

// File: rtl/noc_traffic_monitor_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : noc_mon_lfsr
// Description : Free-running Galois LFSR. It produces the pseudo-random
//               ready pattern of the backpressure mode.
//   clk, rst_n : clock, asynchronous active-low reset (loads SEED)
//   o_bits     : low OUT_WIDTH bits of the LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module noc_mon_lfsr
  import noc_pkg::*;
#(
  parameter int unsigned       WIDTH     = C_LFSR_WIDTH,
  parameter int unsigned       OUT_WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS      = C_LFSR_TAPS,
  parameter logic [WIDTH-1:0]  SEED      = C_LFSR_SEED
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  output logic      [OUT_WIDTH-1:0] o_bits
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (r_state[0]) begin
      r_state <= (r_state >> 1) ^ TAPS;
    end else begin
      r_state <= r_state >> 1;
    end
  end

  assign o_bits = r_state[OUT_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/noc_traffic_monitor.sv
`default_nettype none
// ============================================================================
// Module      : noc_traffic_monitor
// Description : Counts packets on NUM_PE NoC egress channels until
//               NUM_PE*PKT_LIMIT packets are seen. It also collects elapsed
//               time, inject-to-eject latency (sum and max) and misrouted
//               packets.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_start       : pulse, IDLE -> RUN
//   i_clear       : clear statistics, back to IDLE
//   bus           : packet bus (data / valid / ready), slave side
//   o_done        : target reached (held until clear/reset)
//   o_busy        : monitor in RUN
//   o_total_pkts  : accepted packets over all channels
//   o_elapsed     : first accepted beat to target cycle (0 until done)
//   o_lat_sum     : saturating latency sum
//   o_lat_max     : largest single latency
//   o_err_count   : saturating count of misrouted packets
// Revision    : 1.0 - initial release
// ============================================================================
module noc_traffic_monitor
  import noc_pkg::*;
#(
  parameter int unsigned NUM_PE     = C_DEF_NUM_PE,
  parameter int unsigned DATA_WIDTH = C_DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_PE),
  parameter int unsigned PKT_LIMIT  = C_DEF_PKT_LIMIT,
  parameter int unsigned TS_WIDTH   = C_DEF_TS_WIDTH,
  parameter int unsigned READY_MODE = 0
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                i_start,
  input  wire logic                i_clear,
  noc_traffic_monitor_if.slave     bus,
  output logic                     o_done,
  output logic                     o_busy,
  output logic [31:0]              o_total_pkts,
  output logic [31:0]              o_elapsed,
  output logic [31:0]              o_lat_sum,
  output logic [TS_WIDTH-1:0]      o_lat_max,
  output logic [15:0]              o_err_count
);

  localparam int unsigned TOTAL_WIDTH = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [31:0] C_TARGET    = 32'(NUM_PE * PKT_LIMIT);

  state_t                r_state;
  state_t                w_state_next;
  logic [31:0]           r_cycle;
  logic [NUM_PE-1:0]     w_ready_src;
  logic [NUM_PE-1:0]     w_acc;

  logic [31:0]           r_total;
  logic [31:0]           r_lat_sum;
  logic [TS_WIDTH-1:0]   r_lat_max;
  logic [15:0]           r_err;
  logic                  r_done;
  logic                  r_started;
  logic [31:0]           r_start_stamp;
  logic [31:0]           r_stop_stamp;

  logic [31:0]           w_cnt;
  logic [15:0]           w_err_inc;
  logic [31:0]           w_lat_batch;
  logic [TS_WIDTH-1:0]   w_lat_peak;
  logic [TS_WIDTH-1:0]   w_lat;
  logic [31:0]           w_total_next;
  logic [32:0]           w_lat_sum_wide;
  logic [16:0]           w_err_wide;

  // Free-running timebase; its low TS_WIDTH bits are the eject timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end

  // Ready source: registered LFSR bits or constant ones. Neither depends on
  // valid, so there is no valid-to-ready combinational path.
  generate
    if (READY_MODE == 1) begin : g_lfsr_ready
      noc_mon_lfsr #(
        .WIDTH     (C_LFSR_WIDTH),
        .OUT_WIDTH (NUM_PE),
        .TAPS      (C_LFSR_TAPS),
        .SEED      (C_LFSR_SEED)
      ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_bits (w_ready_src)
      );
    end else begin : g_always_ready
      assign w_ready_src = '1;
    end
  endgenerate

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) w_state_next = ST_RUN;
        ST_RUN:  if (w_total_next >= C_TARGET) w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_DONE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_busy           = (r_state == ST_RUN);
    bus.o_data_ready = (r_state == ST_RUN) ? w_ready_src : '0;
  end

  assign w_acc = bus.i_data_valid & bus.o_data_ready;

  // Fold every accepted beat of this cycle into one update.
  always_comb begin
    w_cnt       = '0;
    w_err_inc   = '0;
    w_lat_batch = '0;
    w_lat_peak  = r_lat_max;
    w_lat       = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      w_lat = r_cycle[TS_WIDTH-1:0] - bus.i_data[k*TOTAL_WIDTH +: TS_WIDTH];
      if (w_acc[k]) begin
        w_cnt       = w_cnt + 32'd1;
        w_lat_batch = w_lat_batch + 32'(w_lat);
        if (bus.i_data[k*TOTAL_WIDTH + DATA_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(k))
          w_err_inc = w_err_inc + 16'd1;
        if (w_lat > w_lat_peak)
          w_lat_peak = w_lat;
      end
    end
  end

  assign w_total_next   = r_total + w_cnt;
  assign w_lat_sum_wide = {1'b0, r_lat_sum} + {1'b0, w_lat_batch};
  assign w_err_wide     = {1'b0, r_err} + {1'b0, w_err_inc};

  // Ready is low outside RUN, so w_acc can only be set in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total       <= '0;
      r_lat_sum     <= '0;
      r_lat_max     <= '0;
      r_err         <= '0;
      r_done        <= 1'b0;
      r_started     <= 1'b0;
      r_start_stamp <= '0;
      r_stop_stamp  <= '0;
    end else if (i_clear) begin
      r_total       <= '0;
      r_lat_sum     <= '0;
      r_lat_max     <= '0;
      r_err         <= '0;
      r_done        <= 1'b0;
      r_started     <= 1'b0;
      r_start_stamp <= '0;
      r_stop_stamp  <= '0;
    end else if (r_state == ST_RUN) begin
      r_total   <= w_total_next;
      r_lat_sum <= w_lat_sum_wide[32] ? 32'hFFFF_FFFF : w_lat_sum_wide[31:0];
      r_lat_max <= w_lat_peak;
      r_err     <= w_err_wide[16] ? 16'hFFFF : w_err_wide[15:0];
      if (|w_acc && !r_started) begin
        r_started     <= 1'b1;
        r_start_stamp <= r_cycle;
      end
      if (w_state_next == ST_DONE) begin
        r_done       <= 1'b1;
        r_stop_stamp <= r_cycle;
      end
    end
  end

  assign o_done       = r_done;
  assign o_total_pkts = r_total;
  assign o_elapsed    = r_done ? (r_stop_stamp - r_start_stamp) : 32'd0;
  assign o_lat_sum    = r_lat_sum;
  assign o_lat_max    = r_lat_max;
  assign o_err_count  = r_err;

endmodule
`default_nettype wire

// File: doc/noc_traffic_monitor.md
NOC_TRAFFIC_MONITOR -- requirements
Module: noc_traffic_monitor

Interface
REQ-001 Parameter NUM_PE, default 8: number of monitored NoC egress channels.
REQ-002 Parameter DATA_WIDTH, default 32: payload bits per packet.
REQ-003 Parameter ADDR_WIDTH, default $clog2(NUM_PE): destination field width; packet width TOTAL_WIDTH = DATA_WIDTH+ADDR_WIDTH.
REQ-004 Parameter PKT_LIMIT, default 100: packets expected per channel; target = NUM_PE*PKT_LIMIT.
REQ-005 Parameter TS_WIDTH, default 16: inject-timestamp width, taken from payload bits [TS_WIDTH-1:0].
REQ-006 Parameter READY_MODE, default 0: 0 = always ready in RUN, 1 = LFSR backpressure.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 i_start  in  1  one-cycle pulse, IDLE->RUN.
REQ-010 i_clear  in  1  synchronous clear of statistics, return to IDLE.
REQ-011 i_data  in  NUM_PE*TOTAL_WIDTH  packets; channel k at [k*TOTAL_WIDTH +: TOTAL_WIDTH], address in top ADDR_WIDTH bits.
REQ-012 i_data_valid  in  NUM_PE  per-channel valid.
REQ-013 o_data_ready  out  NUM_PE  per-channel ready.
REQ-014 o_done  out  1  target reached, held until clear/reset.
REQ-015 o_busy  out  1  high in RUN.
REQ-016 o_total_pkts  out  32  accepted packets, all channels.
REQ-017 o_elapsed  out  32  cycles from first accepted packet to target-reaching cycle.
REQ-018 o_lat_sum  out  32  saturating latency sum.
REQ-019 o_lat_max  out  TS_WIDTH  maximum single latency.
REQ-020 o_err_count  out  16  misrouted packets, saturating.

Function
REQ-021 States IDLE, RUN, DONE; IDLE->RUN on i_start; RUN->DONE when post-update total >= target; DONE->IDLE only on i_clear.
REQ-022 Free-running 32-bit cycle counter from reset, wraps.
REQ-023 Beat on channel k accepted iff i_data_valid[k] & o_data_ready[k] in RUN; no acceptance in IDLE/DONE (ready low).
REQ-024 READY_MODE 0: o_data_ready = all ones in RUN. READY_MODE 1: ready[k] = LFSR bit k in RUN, with LFSR advancing every cycle; ready is a registered value with no combinational path from valid.
REQ-025 Simultaneous beats: total increments by popcount of accepted beats that cycle; overshoot allowed and counted.
REQ-026 Start stamp captured on first accepted beat after entering RUN; o_elapsed = stop stamp - start stamp (mod 2^32), valid when o_done=1, 0 otherwise.
REQ-027 Latency per beat = (cycle[TS_WIDTH-1:0] - ts) mod 2^TS_WIDTH; multiple beats per cycle summed in one cycle.
REQ-028 o_lat_sum saturates at 32'hFFFF_FFFF; o_lat_max updates when a new latency is strictly greater.
REQ-029 Address field != k on channel k increments o_err_count (per beat, saturate 16'hFFFF); packet still counted.
REQ-030 Statistics outputs registered, updated one cycle after the accepting edge; o_done asserts same edge as DONE entry.
REQ-031 i_start outside IDLE ignored; i_clear overrides i_start and any same-cycle beat.
REQ-032 i_clear zeroes all statistics, start/stop stamps and o_done; LFSR and cycle counter keep running.

Reset
REQ-033 rst_n low: state IDLE, all outputs 0, ready 0, cycle counter 0, LFSR seed nonzero 'h1 (per-channel taps), effective immediately and asynchronously; mid-RUN reset discards all statistics.

Structure
REQ-034 Shared package noc_pkg holds state enum, default widths, and LFSR seed/tap constants.
REQ-035 One sub-module, noc_mon_lfsr (parametrised width >= NUM_PE, Galois), instantiated only when READY_MODE=1.

Verification
REQ-036 NUM_PE=8, PKT_LIMIT=100, all channels valid every cycle, READY_MODE 0 -> o_done after 100 RUN cycles, o_total_pkts=800, o_elapsed=99.
REQ-037 Channel 3 sends address 5 twice -> o_err_count=2, o_total_pkts includes both.
REQ-038 Packet ts=16'hFFFE accepted at cycle[15:0]=16'h0003 -> latency 5, o_lat_max=5.
REQ-039 READY_MODE 1, valid held -> no beat counted when ready low; total equals sum of ready&valid.
REQ-040 rst_n low mid-RUN at total=37 -> all outputs 0 asynchronously, IDLE; i_clear in DONE -> IDLE, o_done=0.
